// File: rtl/multi_mixer.sv
// multi_mixer: quadrature encoders -> sync + tick-sampled debounce -> x1 decode -> level -> PWM.
// Level moves 2 clk + DB_DEPTH..DB_DEPTH+1 ticks after an input edge; no backpressure. MULTI_MIXER_SAT_EN saturates levels, else wrap.
module multi_mixer #(
  parameter int CHANNELS  = 3,
  parameter int PWM_WIDTH = 8,
  parameter int DIV_WIDTH = 6,
  parameter int DB_DEPTH  = 4,
  parameter int STEP      = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [CHANNELS-1:0]           enc_a,
  input  logic [CHANNELS-1:0]           enc_b,
  output logic [CHANNELS-1:0]           pwm_out,
  output logic [CHANNELS*PWM_WIDTH-1:0] level_out
);

  localparam logic [PWM_WIDTH-1:0] STEP_L  = PWM_WIDTH'(STEP);
  localparam logic [PWM_WIDTH:0]   STEP_X  = (PWM_WIDTH+1)'(STEP);
  localparam logic [PWM_WIDTH-1:0] LVL_MAX = '1;

  logic [DIV_WIDTH-1:0] r_div;
  logic [PWM_WIDTH-1:0] r_cnt;
  logic                 w_tick;

  assign w_tick = &r_div;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div <= '0;
      r_cnt <= '0;
    end else begin
      r_div <= r_div + 1'b1;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [1:0]           r_a_sync;
    logic [1:0]           r_b_sync;
    logic [DB_DEPTH-1:0]  r_a_smp;
    logic [DB_DEPTH-1:0]  r_b_smp;
    logic [DB_DEPTH-1:0]  w_a_shift;
    logic [DB_DEPTH-1:0]  w_b_shift;
    logic                 r_a_db;
    logic                 r_b_db;
    logic                 r_a_prev;
    logic                 r_pwm;
    logic [PWM_WIDTH-1:0] r_level;
    logic [PWM_WIDTH-1:0] w_level_nxt;
    logic                 w_rise;

    assign w_a_shift = {r_a_smp[DB_DEPTH-2:0], r_a_sync[1]};
    assign w_b_shift = {r_b_smp[DB_DEPTH-2:0], r_b_sync[1]};
    // Only a rising debounced A counts; B picks the direction.
    assign w_rise    = w_tick & r_a_db & ~r_a_prev;

`ifdef MULTI_MIXER_SAT_EN
    logic [PWM_WIDTH:0] w_sum;
    logic [PWM_WIDTH:0] w_diff;

    always_comb begin
      w_sum       = {1'b0, r_level} + STEP_X;
      w_diff      = {1'b0, r_level} - STEP_X;
      w_level_nxt = r_level;
      if (w_rise) begin
        if (!r_b_db) w_level_nxt = w_sum[PWM_WIDTH]  ? LVL_MAX : w_sum[PWM_WIDTH-1:0];
        else         w_level_nxt = w_diff[PWM_WIDTH] ? '0      : w_diff[PWM_WIDTH-1:0];
      end
    end
`else
    always_comb begin
      w_level_nxt = r_level;
      if (w_rise) w_level_nxt = r_b_db ? (r_level - STEP_L) : (r_level + STEP_L);
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_a_sync <= '0;
        r_b_sync <= '0;
        r_a_smp  <= '0;
        r_b_smp  <= '0;
        r_a_db   <= 1'b0;
        r_b_db   <= 1'b0;
        r_a_prev <= 1'b0;
        r_level  <= '0;
        r_pwm    <= 1'b0;
      end else begin
        r_a_sync <= {r_a_sync[0], enc_a[i]};
        r_b_sync <= {r_b_sync[0], enc_b[i]};
        if (w_tick) begin
          r_a_smp <= w_a_shift;
          r_b_smp <= w_b_shift;
          if ((&w_a_shift) || (~|w_a_shift)) r_a_db <= w_a_shift[0];
          if ((&w_b_shift) || (~|w_b_shift)) r_b_db <= w_b_shift[0];
          r_a_prev <= r_a_db;
          r_level  <= w_level_nxt;
        end
        r_pwm <= (r_cnt < r_level);
      end
    end

    assign pwm_out[i]                          = r_pwm;
    assign level_out[i*PWM_WIDTH +: PWM_WIDTH] = r_level;
  end

  // Compare against LVL_MAX keeps the constant referenced in the wrap build too.
  logic w_unused;
  assign w_unused = &{1'b0, LVL_MAX, STEP_X};

endmodule

// File: tb/tb_multi_mixer.sv
// Bench for multi_mixer: detent-level model with an allowed change window, per-cycle compare, literal pins.
module tb_multi_mixer;
  localparam int CH = 3;
  localparam int PW = 8;
  localparam int DW = 2;
  localparam int DB = 4;
  localparam int ST = 1;
  localparam int TK = 1 << DW;
  localparam int LO_LAT = 2 + (DB - 1) * TK;
  localparam int HI_LAT = 2 + (DB + 1) * TK;

  logic            clk   = 1'b0;
  logic            reset = 1'b0;
  logic [CH-1:0]   enc_a = '0;
  logic [CH-1:0]   enc_b = '0;
  logic [CH-1:0]   pwm_out;
  logic [CH*PW-1:0] level_out;

  always #5 clk = ~clk;

  multi_mixer #(
    .CHANNELS(CH), .PWM_WIDTH(PW), .DIV_WIDTH(DW), .DB_DEPTH(DB), .STEP(ST)
  ) dut (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
    .pwm_out(pwm_out), .level_out(level_out)
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  // Model: before m_lo the level is m_old, from m_hi on it is m_new, in between either.
  int m_old [CH];
  int m_new [CH];
  int m_lo  [CH];
  int m_hi  [CH];

  int c_act, c_n, c_el;
  logic c_pwm;

  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int lvl(input int ch);
    return int'(level_out[ch*PW +: PW]);
  endfunction

  function automatic int step_lvl(input int v, input bit up);
`ifdef MULTI_MIXER_SAT_EN
    if (up) return (v + ST > 255) ? 255 : v + ST;
    else    return (v - ST < 0) ? 0 : v - ST;
`else
    if (up) return (v + ST) % 256;
    else    return (v + 256 - ST) % 256;
`endif
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      check(level_out == '0, "reset_level", int'(level_out), 0);
      check(pwm_out == '0, "reset_pwm", int'(pwm_out), 0);
    end else begin
      for (int ch = 0; ch < CH; ch++) begin
        c_act = lvl(ch);
        if (cyc < m_lo[ch])       check(c_act == m_old[ch], "level_early", c_act, m_old[ch]);
        else if (cyc >= m_hi[ch]) check(c_act == m_new[ch], "level_settled", c_act, m_new[ch]);
        else check(c_act == m_old[ch] || c_act == m_new[ch], "level_window", c_act, m_new[ch]);
        if (cyc == 0) begin
          check(pwm_out[ch] == 1'b0, "pwm_first", int'(pwm_out[ch]), 0);
        end else begin
          c_n = cyc - 1;
          if (c_n < m_lo[ch] || c_n >= m_hi[ch]) begin
            c_el  = (c_n < m_lo[ch]) ? m_old[ch] : m_new[ch];
            c_pwm = ((c_n % 256) < c_el);
            check(pwm_out[ch] == c_pwm, "pwm_cycle", int'(pwm_out[ch]), int'(c_pwm));
          end
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic a_rise(input logic [CH-1:0] mask);
    for (int ch = 0; ch < CH; ch++) begin
      if (mask[ch]) begin
        m_old[ch] = m_new[ch];
        m_new[ch] = step_lvl(m_new[ch], enc_b[ch] == 1'b0);
        m_lo[ch]  = cyc + LO_LAT;
        m_hi[ch]  = cyc + HI_LAT;
      end
    end
    enc_a = enc_a | mask;
  endtask

  task automatic detent_cw(input logic [CH-1:0] mask);
    a_rise(mask);          wait_clk(40);
    enc_b = enc_b | mask;  wait_clk(40);
    enc_a = enc_a & ~mask; wait_clk(40);
    enc_b = enc_b & ~mask; wait_clk(40);
  endtask

  task automatic detent_ccw(input logic [CH-1:0] mask);
    enc_b = enc_b | mask;  wait_clk(40);
    a_rise(mask);          wait_clk(40);
    enc_b = enc_b & ~mask; wait_clk(40);
    enc_a = enc_a & ~mask; wait_clk(40);
  endtask

  task automatic count_high(input int ch, output int cnt);
    cnt = 0;
    repeat (256) begin
      @(negedge clk);
      if (pwm_out[ch]) cnt++;
    end
    #1;
  endtask

  task automatic model_clear();
    for (int ch = 0; ch < CH; ch++) begin
      m_old[ch] = 0; m_new[ch] = 0; m_lo[ch] = 0; m_hi[ch] = 0;
    end
  endtask

  int hi_cnt;
  int exp_v;

  initial begin
    model_clear();
    reset = 1'b0;
    wait_clk(3);
    check(level_out == '0, "lit_reset_level", int'(level_out), 0);
    check(pwm_out == '0, "lit_reset_pwm", int'(pwm_out), 0);
    reset = 1'b1;

    wait_clk(1024);
    check(level_out == '0, "lit_idle_level", int'(level_out), 0);
    check(pwm_out == '0, "lit_idle_pwm", int'(pwm_out), 0);

    repeat (10) detent_cw(3'b010);
    check(lvl(1) == 10, "lit_cw10_level1", lvl(1), 10);
    check(lvl(0) == 0, "lit_cw10_level0", lvl(0), 0);
    check(lvl(2) == 0, "lit_cw10_level2", lvl(2), 0);
    count_high(1, hi_cnt);
    check(hi_cnt == 10, "lit_pwm1_duty", hi_cnt, 10);

    repeat (5) begin
      enc_a[0] = 1'b1; wait_clk(12);
      enc_a[0] = 1'b0; wait_clk(28);
    end
    wait_clk(40);
    check(lvl(0) == 0, "lit_glitch_level0", lvl(0), 0);

    repeat (2) detent_cw(3'b111);
    check(lvl(0) == 2, "lit_sim_level0", lvl(0), 2);
    check(lvl(1) == 12, "lit_sim_level1", lvl(1), 12);
    check(lvl(2) == 2, "lit_sim_level2", lvl(2), 2);

    repeat (5) detent_ccw(3'b100);
`ifdef MULTI_MIXER_SAT_EN
    exp_v = 0;
`else
    exp_v = 253;
`endif
    check(lvl(2) == exp_v, "lit_ccw5_level2", lvl(2), exp_v);

    // A held long enough to be debounced but not yet decoded, then reset.
    enc_a[0] = 1'b1;
    wait_clk(18);
    reset = 1'b0;
    enc_a = '0;
    enc_b = '0;
    model_clear();
    #1;
    check(level_out == '0, "lit_midreset_level", int'(level_out), 0);
    check(pwm_out == '0, "lit_midreset_pwm", int'(pwm_out), 0);
    wait_clk(1);
    reset = 1'b1;
    wait_clk(100);
    check(level_out == '0, "lit_postreset_level", int'(level_out), 0);

    detent_ccw(3'b001);
`ifdef MULTI_MIXER_SAT_EN
    exp_v = 0;
`else
    exp_v = 255;
`endif
    check(lvl(0) == exp_v, "lit_underflow_level0", lvl(0), exp_v);
    count_high(0, hi_cnt);
    check(hi_cnt == exp_v, "lit_pwm0_duty", hi_cnt, exp_v);

    detent_cw(3'b001);
`ifdef MULTI_MIXER_SAT_EN
    exp_v = 1;
`else
    exp_v = 0;
`endif
    check(lvl(0) == exp_v, "lit_overflow_level0", lvl(0), exp_v);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multi_mixer.md
MULTI_MIXER -- requirements
Module: multi_mixer

Interface
REQ-001 SHALL have parameter CHANNELS, default 3: number of encoder/PWM channels (1..8).
REQ-002 SHALL have parameter PWM_WIDTH, default 8: level and PWM counter width (4..12).
REQ-003 SHALL have parameter DIV_WIDTH, default 6: sample-tick divider width; one tick every 2^DIV_WIDTH clk cycles.
REQ-004 SHALL have parameter DB_DEPTH, default 4: consecutive equal tick samples needed to accept an input change (2..16).
REQ-005 SHALL have parameter STEP, default 1: level change per detent (1..2^(PWM_WIDTH-1)).
REQ-006 clk  input  1  the single clock; every flop in the block uses its rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 enc_a  input  CHANNELS  quadrature A per channel, asynchronous to clk.
REQ-009 enc_b  input  CHANNELS  quadrature B per channel, asynchronous to clk.
REQ-010 pwm_out  output  CHANNELS  registered PWM output per channel.
REQ-011 level_out  output  CHANNELS*PWM_WIDTH  current level; channel i occupies bits [i*PWM_WIDTH +: PWM_WIDTH].

Function
REQ-012 Each enc_a/enc_b bit SHALL pass through a two-flop synchronizer before any other use.
REQ-013 A DIV_WIDTH-bit free-running divider SHALL assert a one-cycle internal tick when its value equals all-ones.
REQ-014 On a tick, each synchronized input SHALL shift into a DB_DEPTH-deep sample register.
REQ-015 The debounced value SHALL take the sampled value only when all DB_DEPTH samples are equal; otherwise it holds.
REQ-016 Within one channel, the decoder SHALL compare debounced A with its value at the previous tick.
REQ-017 A 0->1 transition of debounced A with debounced B=0 SHALL add STEP to the level; with B=1 it SHALL subtract STEP.
REQ-018 A 1->0 transition of A, and any change of B alone, SHALL leave the level unchanged (x1 decoding).
REQ-019 Each channel's level SHALL be a PWM_WIDTH-bit register updated only on tick cycles; channels SHALL be fully independent.
REQ-020 Out-of-range arithmetic SHALL follow the REQ-031/REQ-032 rules.
REQ-021 The block SHALL have one shared PWM_WIDTH-bit counter that increments every clk cycle and wraps from 2^PWM_WIDTH-1 to 0.
REQ-022 pwm_out[i] SHALL be registered from (counter < level_i), giving one clk of latency.
REQ-023 level 0 SHALL give constant low.
REQ-024 level 2^PWM_WIDTH-1 SHALL give high for all but one cycle per period.
REQ-025 level_out SHALL be driven directly from the level registers, with no added latency.
REQ-026 An input edge SHALL change the level within 2 clk + (DB_DEPTH+1) ticks, and never earlier than 2 clk + (DB_DEPTH-1) ticks.

Reset
REQ-027 While reset is low, all flops SHALL clear asynchronously: synchronizers, samples, debounced values, previous-A, divider, PWM counter and levels all go to 0.
REQ-028 pwm_out SHALL be 0 and level_out SHALL be 0 during reset.
REQ-029 Reset asserted mid-debounce or mid-period SHALL discard the partial state; no level step SHALL occur from pre-reset history.
REQ-030 After reset deasserts, the first tick SHALL occur 2^DIV_WIDTH-1 cycles later.

Configuration
REQ-031 With macro MULTI_MIXER_SAT_EN defined, levels SHALL saturate: an increment beyond 2^PWM_WIDTH-1 clamps to 2^PWM_WIDTH-1, and a decrement below 0 clamps to 0.
REQ-032 Without MULTI_MIXER_SAT_EN, levels SHALL wrap modulo 2^PWM_WIDTH: 255+1 gives 0, and 0-1 gives 255 (PWM_WIDTH=8, STEP=1).

Verification (DIV_WIDTH=2, DB_DEPTH=4, PWM_WIDTH=8, CHANNELS=3)
REQ-033 Reset then idle inputs -> level_out==0 and pwm_out==0 for 1024 cycles.
REQ-034 Ten clean CW detents on channel 1 (A rises while B=0, each phase held 40 clk) -> level1==10, level0==level2==0, and pwm_out[1] high 10 of every 256 cycles.
REQ-035 Glitch pulses on enc_a[0] of 3 ticks' length (12 clk), repeated -> level0 remains 0.
REQ-036 Starting from level2==2, five CCW detents -> level2==0 with MULTI_MIXER_SAT_EN, and level2==253 without it.
REQ-037 Reset pulled low for 1 clk midway through a debounce window -> all outputs 0 immediately, and no step follows.
REQ-038 Simultaneous CW detents on all three channels -> each level increments by exactly 1 per detent.
